gf_table_arbiter: RTL

//   Shares one GF(2^8) log/antilog table port set (add_pow1/add_pow2 -> pow1/pow2, add_dec1 -> dec1)

---
 rtl/rs_pkg.sv | 19 +
 rtl/rr_pick.sv | 51 +++++
 rtl/gf_table_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_pkg
// Description : Shared RS decoder constants and table-arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

    localparam int         GF_W     = 8;
    localparam logic [7:0] LOG_ZERO = 8'hFF;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first eligible bit at or
//               after rr_ptr, wrapping at NREQ. Outputs one-hot and index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   index,
    output logic            found
);

    logic [2*NREQ-1:0] w_dbl;
    logic [PW-1:0]     w_off;
    logic [PW:0]       w_sum;

    // Rotate so rr_ptr lands at bit 0; the lowest set bit is then the winner.
    always_comb begin
        w_dbl = {eligible, eligible} >> rr_ptr;
        w_off = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                found = 1'b1;
                w_off = PW'(k);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, rr_ptr} + {1'b0, w_off};
        if (w_sum >= (PW + 1)'(NREQ)) begin
            w_sum = w_sum - (PW + 1)'(NREQ);
        end
        index = w_sum[PW-1:0];
    end

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_onehot
            assign onehot[g] = found && (index == PW'(g));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/gf_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gf_table_arbiter
// Description : Round-robin, held-ownership arbiter sharing one GF(2^8)
//               log/antilog table between NREQ decoder engines, with a hold
//               watchdog that revokes a hung owner.
// Revision    : 1.0 - initial release
// ============================================================================
module gf_table_arbiter
    import rs_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int MAX_HOLD = 511,
    parameter int CW       = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    input  logic [NREQ*GF_W-1:0] req_pow1,
    input  logic [NREQ*GF_W-1:0] req_pow2,
    input  logic [NREQ*GF_W-1:0] req_dec1,
    output logic [GF_W-1:0]      add_pow1,
    output logic [GF_W-1:0]      add_pow2,
    output logic [GF_W-1:0]      add_dec1,
    input  logic [GF_W-1:0]      pow1,
    input  logic [GF_W-1:0]      pow2,
    input  logic [GF_W-1:0]      dec1,
    output logic [NREQ*GF_W-1:0] rsp_pow1,
    output logic [NREQ*GF_W-1:0] rsp_pow2,
    output logic [NREQ*GF_W-1:0] rsp_dec1,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      r_state,    w_state_nxt;
    logic [NREQ-1:0] r_gnt,      w_gnt_nxt;
    logic [NREQ-1:0] r_mask,     w_mask_nxt;
    logic [NREQ-1:0] w_mask_set;
    logic [PW-1:0]   r_rr_ptr,   w_rr_ptr_nxt;
    logic [PW-1:0]   r_owner,    w_owner_nxt;
    logic [CW-1:0]   r_hold_cnt, w_hold_cnt_nxt;
    logic            r_timeout,  w_timeout_nxt;

    logic [NREQ-1:0] w_eligible;
    logic [NREQ-1:0] w_pick;
    logic [PW-1:0]   w_pick_idx;
    logic            w_pick_found;
    logic            w_owner_req;
    logic [PW-1:0]   w_owner_inc;

    assign w_eligible  = req & ~r_mask;
    assign w_owner_req = |(req & r_gnt);
    assign w_owner_inc = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .eligible (w_eligible),
        .rr_ptr   (r_rr_ptr),
        .onehot   (w_pick),
        .index    (w_pick_idx),
        .found    (w_pick_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ARB_IDLE;
            r_gnt      <= '0;
            r_mask     <= '0;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_mask     <= w_mask_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_hold_cnt_nxt = r_hold_cnt;
        w_timeout_nxt  = 1'b0;
        w_mask_set     = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_found) begin
                    w_gnt_nxt      = w_pick;
                    w_owner_nxt    = w_pick_idx;
                    w_hold_cnt_nxt = '0;
                    w_state_nxt    = ARB_OWN;
                end
            end
            ARB_OWN: begin
                // A voluntary release wins over the watchdog on the same cycle.
                if (!w_owner_req) begin
                    w_gnt_nxt    = '0;
                    w_rr_ptr_nxt = w_owner_inc;
                    w_state_nxt  = ARB_GAP;
                end else if (r_hold_cnt == CW'(MAX_HOLD)) begin
                    w_gnt_nxt     = '0;
                    w_mask_set    = r_gnt;
                    w_timeout_nxt = 1'b1;
                    w_rr_ptr_nxt  = w_owner_inc;
                    w_state_nxt   = ARB_GAP;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            ARB_GAP: begin
                w_state_nxt = ARB_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ARB_IDLE;
            end
        endcase
        // A masked engine is forgiven once it lowers its request.
        w_mask_nxt = (r_mask & req) | w_mask_set;
    end

    // Grant is one-hot, so OR-ing the gated slices selects the owner's slice.
    always_comb begin
        add_pow1 = '0;
        add_pow2 = '0;
        add_dec1 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                add_pow1 = add_pow1 | req_pow1[GF_W*i +: GF_W];
                add_pow2 = add_pow2 | req_pow2[GF_W*i +: GF_W];
                add_dec1 = add_dec1 | req_dec1[GF_W*i +: GF_W];
            end
        end
    end

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_rsp
            assign rsp_pow1[GF_W*g +: GF_W] = r_gnt[g] ? pow1 : LOG_ZERO;
            assign rsp_pow2[GF_W*g +: GF_W] = r_gnt[g] ? pow2 : LOG_ZERO;
            assign rsp_dec1[GF_W*g +: GF_W] = r_gnt[g] ? dec1 : '0;
        end
    endgenerate

    assign gnt         = r_gnt;
    assign busy        = |r_gnt;
    assign timeout_err = r_timeout;

endmodule
`default_nettype wire
